// File: rtl/encoded_memory_ctrl.sv
// Keyed scratch memory: words are stored XOR-encoded with a per-address key, reads are registered.
// Optional ENCMEM_READ_DECODE_EN makes reads return plaintext (stored word ^ key) instead of the raw word.
module encoded_memory_ctrl #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CLR,
   input  logic              REQ,
   input  logic [1:0]        OP,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [WIDTH-1:0]  WDATA,
   output logic [WIDTH-1:0]  RDATA,
   output logic              RVALID,
   output logic              BUSY
);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ACC   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam logic [7:0] BASE_KEY [8] = '{8'h00, 8'h55, 8'hAA, 8'h33,
                                          8'hCC, 8'h0F, 8'hF0, 8'hFF};

   typedef enum logic {INIT, IDLE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0]  mem [DEPTH];

   logic             accept, addr_ok, is_read;
   logic [WIDTH-1:0] key_a, rd_word;

   // Address bits above bit 2 are dropped, giving base[i mod 8].
   function automatic logic [WIDTH-1:0] key_of(input logic [ADDR_W-1:0] a);
      logic [2:0] idx;
      idx = 3'(a);
      return {(WIDTH/8){BASE_KEY[idx]}};
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (CLR) begin
         state_nxt = INIT;
         cnt_nxt   = '0;
      end else if (state == INIT) begin
         if (cnt == LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   assign BUSY    = (state == INIT);
   assign accept  = (state == IDLE) && REQ && !CLR;
   assign is_read = accept && (OP == OP_READ);
   assign addr_ok = {1'b0, ADDR} < (ADDR_W+1)'(DEPTH);
   assign key_a   = key_of(ADDR);

`ifdef ENCMEM_READ_DECODE_EN
   assign rd_word = mem[ADDR] ^ key_a;
`else
   assign rd_word = mem[ADDR];
`endif

   // NOTE: the array has no reset; it is cleared by the INIT sweep, which keeps it mappable to RAM.
   always_ff @(posedge CLK) begin
      if (RST_N && !CLR) begin
         if (state == INIT) begin
            mem[cnt] <= '0;
         end else if (accept && addr_ok) begin
            case (OP)
               OP_WRITE: mem[ADDR] <= WDATA ^ key_a;
               OP_ACC:   mem[ADDR] <= mem[ADDR] ^ WDATA ^ key_a;
               OP_CLEAR: mem[ADDR] <= '0;
               default:  ;
            endcase
         end
      end
   end

   // RDATA holds between reads; only RVALID drops.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         RDATA  <= '0;
         RVALID <= 1'b0;
      end else begin
         RVALID <= is_read;
         if (is_read) RDATA <= addr_ok ? rd_word : '0;
      end
   end

endmodule

// File: tb/tb_encoded_memory_ctrl.sv
// Directed self-checking bench for encoded_memory_ctrl (WIDTH=8, DEPTH=8); honours ENCMEM_READ_DECODE_EN.
module tb_encoded_memory_ctrl;

   logic       CLK = 1'b0;
   logic       RST_N, CLR, REQ, RVALID, BUSY;
   logic [1:0] OP;
   logic [2:0] ADDR;
   logic [7:0] WDATA, RDATA;

   int checks   = 0;
   int failures = 0;
   int n;

`ifdef ENCMEM_READ_DECODE_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif

   localparam logic [7:0] KEYS   [8] = '{8'h00, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0, 8'hFF};
   localparam logic [7:0] RAW_AA [8] = '{8'hAA, 8'hFF, 8'h00, 8'h99, 8'h66, 8'hA5, 8'h5A, 8'h55};

   encoded_memory_ctrl #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
      .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .REQ(REQ), .OP(OP), .ADDR(ADDR),
      .WDATA(WDATA), .RDATA(RDATA), .RVALID(RVALID), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raw stored word -> value a read returns in this build.
   function automatic logic [7:0] rd_exp(input logic [7:0] raw, input int a);
      return DEC ? (raw ^ KEYS[a]) : raw;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_op(input logic [1:0] op, input int a, input logic [7:0] d);
      REQ = 1'b1; OP = op; ADDR = 3'(a); WDATA = d;
      step();
      REQ = 1'b0;
   endtask

   task automatic do_read(input int a, input logic [7:0] exp, input string tag);
      do_op(2'b00, a, 8'h00);
      check({tag, "_rvalid"}, 32'(RVALID), 32'd1);
      check({tag, "_rdata"}, 32'(RDATA), 32'(exp));
      step();
      check({tag, "_pulse"}, 32'(RVALID), 32'd0);
      check({tag, "_hold"}, 32'(RDATA), 32'(exp));
   endtask

   // Steps until BUSY drops (bounded); returns number of steps taken.
   task automatic count_busy(input string tag, output int cnt);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         cnt++;
         if (cnt == 3) begin REQ = 1'b1; OP = 2'b00; ADDR = 3'd2; end
         if (cnt == 4) REQ = 1'b0;
         check({tag, "_no_rvalid"}, 32'(RVALID), 32'd0);
         if (!BUSY) break;
      end
      check({tag, "_busy_len"}, 32'(cnt), 32'd8);
   endtask

   initial begin
      RST_N = 1'b0; CLR = 1'b0; REQ = 1'b0; OP = 2'b00; ADDR = '0; WDATA = '0;
      repeat (3) step();
      check("rst_rdata", 32'(RDATA), 32'h0);
      check("rst_rvalid", 32'(RVALID), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd1);

      RST_N = 1'b1;
      count_busy("init", n);
      check("init_rdata", 32'(RDATA), 32'h0);
      for (int a = 0; a < 8; a++) do_read(a, rd_exp(8'h00, a), $sformatf("swept%0d", a));

      // Each write is immediately followed by a read of the same address.
      for (int a = 0; a < 8; a++) begin
         do_op(2'b01, a, 8'hAA);
         do_read(a, rd_exp(RAW_AA[a], a), $sformatf("wr_aa%0d", a));
      end

      do_op(2'b10, 1, 8'h0F);
      do_read(1, rd_exp(8'hA5, 1), "acc1");
      do_op(2'b11, 1, 8'h77);
      do_read(1, rd_exp(8'h00, 1), "clr1");
      do_read(2, rd_exp(8'h00, 2), "addr2_kept");

      do_op(2'b01, 5, 8'h3C);
      do_read(5, rd_exp(8'h33, 5), "wr3c");

      // Back-to-back reads, one per cycle.
      REQ = 1'b1; OP = 2'b00; ADDR = 3'd0;
      step();
      check("b2b0", 32'({RVALID, RDATA}), 32'({1'b1, rd_exp(8'hAA, 0)}));
      ADDR = 3'd7;
      step();
      REQ = 1'b0;
      check("b2b7", 32'({RVALID, RDATA}), 32'({1'b1, rd_exp(8'h55, 7)}));
      step();

      // CLR together with a write: write dropped, sweep runs, mid-sweep REQ ignored.
      CLR = 1'b1; REQ = 1'b1; OP = 2'b01; ADDR = 3'd0; WDATA = 8'h12;
      step();
      CLR = 1'b0; REQ = 1'b0;
      check("clr_busy", 32'(BUSY), 32'd1);
      check("clr_no_rvalid", 32'(RVALID), 32'd0);
      count_busy("clr", n);
      for (int a = 0; a < 8; a++) do_read(a, rd_exp(8'h00, a), $sformatf("clr_rd%0d", a));

      // CLR during INIT restarts the sweep.
      CLR = 1'b1; step(); CLR = 1'b0;
      repeat (3) step();
      CLR = 1'b1; step(); CLR = 1'b0;
      count_busy("restart", n);

      // Reset right after a read REQ kills the pending result.
      do_op(2'b01, 5, 8'h3C);
      do_op(2'b00, 5, 8'h00);
      check("pre_rst_rvalid", 32'(RVALID), 32'd1);
      check("pre_rst_rdata", 32'(RDATA), 32'(rd_exp(8'h33, 5)));
      RST_N = 1'b0;
      step();
      check("midrst_rvalid", 32'(RVALID), 32'd0);
      check("midrst_rdata", 32'(RDATA), 32'h0);
      check("midrst_busy", 32'(BUSY), 32'd1);
      RST_N = 1'b1;
      count_busy("rst2", n);
      do_read(5, rd_exp(8'h00, 5), "rst2_rd5");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
